// File: rtl/fpu_addsub_result_queue.sv
// fpu_addsub_result_queue: FWFT result/flag buffer behind the fp64 add/sub unit.
// Define FPU_RESULT_STATS_EN to add the exc_cnt/zero_cnt push statistics.
module fpu_addsub_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_result,
    input  logic             in_exception,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic             out_exception,
    output logic             out_zero,
    output logic             out_sign,
`ifdef FPU_RESULT_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      exc_cnt,
    output logic [15:0]      zero_cnt,
`endif
    output logic [CNT_W-1:0] out_count
);
    localparam int PW = $clog2(DEPTH);
    logic [66:0]      mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, zero_in;
    logic [66:0]      head;
    assign in_ready  = count != CNT_W'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign zero_in   = (in_result[62:0] == 63'd0) && !in_exception;
    assign head      = mem[rd_ptr];
    assign out_result    = head[66:3];
    assign out_exception = head[2];
    assign out_zero      = head[1];
    assign out_sign      = head[0];
    assign out_count     = count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_result, in_exception, zero_in, in_result[63]};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
`ifdef FPU_RESULT_STATS_EN
    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_cnt  <= '0;
            zero_cnt <= '0;
        end else begin
            exc_cnt  <= stats_clr ? 16'd0 : (push && in_exception && exc_cnt != 16'hFFFF) ? exc_cnt + 16'd1 : exc_cnt;
            zero_cnt <= stats_clr ? 16'd0 : (push && zero_in && zero_cnt != 16'hFFFF) ? zero_cnt + 16'd1 : zero_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_fpu_addsub_result_queue.sv
// tb_fpu_addsub_result_queue: directed checks of the FWFT result queue.
module tb_fpu_addsub_result_queue;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [63:0] in_result = '0;
    logic        in_exception = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [63:0] out_result;
    logic        out_exception, out_zero, out_sign;
    logic [2:0]  out_count;
`ifdef FPU_RESULT_STATS_EN
    logic        stats_clr = 0;
    logic [15:0] exc_cnt, zero_cnt;
`endif
    int n_checks = 0;
    int n_fail = 0;

    fpu_addsub_result_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_exception(in_exception),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_exception(out_exception), .out_zero(out_zero), .out_sign(out_sign),
`ifdef FPU_RESULT_STATS_EN
        .stats_clr(stats_clr), .exc_cnt(exc_cnt), .zero_cnt(zero_cnt),
`endif
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", out_count); end
        n_checks++; if ({out_result, out_exception, out_zero, out_sign} !== 67'd0) begin n_fail++; $display("FAIL reset_head got %h/%b%b%b want 0", out_result, out_exception, out_zero, out_sign); end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1; in_result = 64'h3FF0000000000000; in_exception = 0;
        step();
        in_valid = 0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_checks++; if (out_result !== 64'h3FF0000000000000) begin n_fail++; $display("FAIL single_result got %h want 3ff0000000000000", out_result); end
        n_checks++; if ({out_zero, out_sign, out_exception} !== 3'b000) begin n_fail++; $display("FAIL single_flags got %b%b%b want 000", out_zero, out_sign, out_exception); end
        n_checks++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", out_count); end
        out_ready = 1;
        step();
        n_checks++; if (out_valid !== 1'b0 || out_count !== 3'd0) begin n_fail++; $display("FAIL single_pop got valid=%b count=%0d want 0/0", out_valid, out_count); end
        step();
        n_checks++; if (out_count !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL empty_pop_ignored got count=%0d ready=%b want 0/1", out_count, in_ready); end
        out_ready = 0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_result = 64'(i);
            step();
        end
        n_checks++; if (in_ready !== 1'b0 || out_count !== 3'd4) begin n_fail++; $display("FAIL fill_full got ready=%b count=%0d want 0/4", in_ready, out_count); end
        in_result = 64'h5;
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (out_count !== 3'd4 || out_result !== 64'h1) begin n_fail++; $display("FAIL fill_hold got count=%0d head=%h want 4/1", out_count, out_result); end
        in_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_result !== 64'(i)) begin n_fail++; $display("FAIL fill_order got valid=%b %h want 1/%h", out_valid, out_result, 64'(i)); end
            out_ready = 1;
            step();
            out_ready = 0;
        end
        n_checks++; if (out_valid !== 1'b0 || out_count !== 3'd0) begin n_fail++; $display("FAIL fill_drained got valid=%b count=%0d want 0/0", out_valid, out_count); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q[$];
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_result = 64'h100 + 64'(i); q.push_back(in_result);
            step();
        end
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_result = 64'h102 + 64'(i);
            n_checks++; if (out_result !== q[0]) begin n_fail++; $display("FAIL b2b_head got %h want %h", out_result, q[0]); end
            step();
            void'(q.pop_front());
            q.push_back(in_result);
            n_checks++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", out_count); end
        end
        in_valid = 0;
        while (q.size() > 0) begin
            n_checks++; if (out_valid !== 1'b1 || out_result !== q[0]) begin n_fail++; $display("FAIL b2b_drain got %b/%h want 1/%h", out_valid, out_result, q[0]); end
            void'(q.pop_front());
            step();
        end
        out_ready = 0;
    endtask

    task automatic flag_case(input logic [63:0] r, input logic e, input logic [2:0] want);
        in_valid = 1; in_result = r; in_exception = e;
        step();
        in_valid = 0; in_exception = 0;
        n_checks++; if ({out_exception, out_zero, out_sign} !== want || out_result !== r) begin n_fail++; $display("FAIL flags_%h got exc/zero/sign=%b%b%b result=%h want %b", r, out_exception, out_zero, out_sign, out_result, want); end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_flags();
        flag_case(64'h8000000000000000, 0, 3'b011);
        flag_case(64'h0000000000000000, 1, 3'b100);
        flag_case(64'hC000000000000000, 0, 3'b001);
        flag_case(64'h0000000000000000, 0, 3'b010);
        flag_case(64'h0000000000000001, 0, 3'b000);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_result = 64'hA0 + 64'(i);
            step();
        end
        in_valid = 0;
        n_checks++; if (out_count !== 3'd3) begin n_fail++; $display("FAIL arst_pre got count=%0d want 3", out_count); end
        #3 rst_n = 0;
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 3'd0 || out_result !== 64'd0) begin n_fail++; $display("FAIL arst_now got ready=%b valid=%b count=%0d head=%h want 1/0/0/0", in_ready, out_valid, out_count, out_result); end
        step();
        rst_n = 1;
        step();
        in_valid = 1; in_result = 64'h7;
        step();
        in_valid = 0;
        n_checks++; if (out_result !== 64'h7 || out_count !== 3'd1) begin n_fail++; $display("FAIL arst_first got %h count=%0d want 7/1", out_result, out_count); end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

`ifdef FPU_RESULT_STATS_EN
    task automatic test_stats();
        stats_clr = 1;
        step();
        stats_clr = 0;
        out_ready = 1;
        in_valid = 1; in_result = 64'd0;
        in_exception = 1;
        for (int i = 0; i < 3; i++) step();
        in_exception = 0;
        for (int i = 0; i < 2; i++) step();
        in_valid = 0;
        n_checks++; if (exc_cnt !== 16'd3 || zero_cnt !== 16'd2) begin n_fail++; $display("FAIL stats_count got exc=%0d zero=%0d want 3/2", exc_cnt, zero_cnt); end
        in_valid = 1; in_exception = 1; stats_clr = 1;
        step();
        in_valid = 0; in_exception = 0; stats_clr = 0;
        n_checks++; if (exc_cnt !== 16'd0 || zero_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clr got exc=%0d zero=%0d want 0/0", exc_cnt, zero_cnt); end
        step();
        out_ready = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flags();
        test_async_reset();
`ifdef FPU_RESULT_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end
endmodule
